imm_field_encoder: RTL and testbench
====================================

Name: imm_field_encoder

Overview:
- Encoder side of the immediate-extension path. Takes a 32-bit constant, picks the narrowest legal immediate form (imm5 ZE, imm15 SE, imm15 ZE, imm20 SE), and emits the packed immediate field plus the 2-bit extension select the decode stage consumes.
- Constants that fit no single form are split into two beats: a HI beat (imm20 SE of bits [31:12]) and a LO beat (imm15 ZE of bits [11:0]).
- Used by the instruction-generation/test-program unit ahead of instruction memory.

Parameters:
- DataSize, 32, constant width; fixed at 32, no other value supported.
- CntWidth, 16, width of the split-event statistics counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  constant offered.
- in_ready  output  1  encoder can accept a constant.
- in_value  input  32  constant to encode.
- allow_mask  input  4  per-form enable, sampled with in_value. Bit0=imm5ZE, bit1=imm15SE, bit2=imm15ZE, bit3=imm20SE.
- out_valid  output  1  beat available.
- out_ready  input  1  consumer accepts beat.
- imm_5bit  output  5  field for select 00; else 0.
- imm_15bit  output  15  field for select 01/10; else 0.
- imm_20bit  output  20  field for select 11; else 0.
- mux4to1_select  output  2  00 imm5ZE, 01 imm15SE, 10 imm15ZE, 11 imm20SE.
- out_hi  output  1  beat is HI half of a split.
- out_last  output  1  final beat of this constant.
- split_count  output  CntWidth  saturating count of split constants.

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE; in_ready=1.
  - out_valid=0; all fields=0; select=00; out_hi=0; out_last=0; split_count=0.
  - Reset mid-transfer discards any pending beat.
- States: IDLE, EMIT_ONE, EMIT_HI, EMIT_LO. in_ready=1 only in IDLE.
- Accept on in_valid&&in_ready at edge N. Form selection, first matching enabled form in priority order:
  - imm5ZE: value[31:5]==0
  - imm15SE: value[31:14] all equal
  - imm15ZE: value[31:15]==0
  - imm20SE: value[31:19] all equal
- If a form matches: go to EMIT_ONE. Drive the field with the low bits of the value and the form's select; out_last=1, out_hi=0.
- If no form matches (including allow_mask=0): go to EMIT_HI.
  - HI beat: imm_20bit=value[31:12], select=11, out_hi=1, out_last=0.
  - split_count increments by 1 at the accept edge, saturating at all-ones.
  - The split path ignores allow_mask.
- EMIT_HI and out_ready: go to EMIT_LO. LO beat: imm_15bit={3'b0,value[11:0]}, select=10, out_hi=0, out_last=1.
- EMIT_ONE or EMIT_LO and out_ready: go to IDLE, out_valid=0.
- Latency: out_valid=1 at cycle N+1, where N is the accept edge. All outputs are registered.
- Throughput: one constant per 2 cycles when single-beat; 3 cycles when split.
- While out_valid && !out_ready, every output holds stable (no glitch, no change).
- in_value and allow_mask are captured at accept; later changes are ignored.
- Fields not used by the current select are driven to 0.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Reset, then in_value=0x0000001F, mask=1111 -> N+1: select=00, imm_5bit=0x1F, out_last=1; out_ready=1 -> in_ready=1 the following cycle.
- in_value=0xFFFFC000 (-16384), mask=1111 -> select=01, imm_15bit=0x4000. Same value with mask=1101 -> select=11, imm_20bit=0xFC000.
- in_value=0x00007FFF, mask=1111 -> select=10, imm_15bit=0x7FFF. Same value with mask=1011 -> select=11, imm_20bit=0x07FFF.
- in_value=0x12345678 -> HI beat: imm_20bit=0x12345, select=11, out_hi=1. Then LO beat: imm_15bit=0x0678, select=10, out_last=1. split_count=1.
- Backpressure: hold out_ready=0 for 5 cycles on the HI beat of 0x80000000 -> outputs stable, in_ready=0. Release -> LO beat imm_15bit=0x0000.
- Assert rst during EMIT_HI -> next cycle out_valid=0, in_ready=1, split_count=0. Also preset split_count to 0xFFFF, split once -> stays 0xFFFF.

Source files
------------

// File: rtl/imm_field_encoder.sv
// Immediate-field encoder: chooses the narrowest enabled immediate form for a
// 32-bit constant, or splits it into a HI (imm20 SE) and LO (imm15 ZE) beat pair.
module imm_field_encoder #(
    parameter int DataSize = 32,
    parameter int CntWidth = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DataSize-1:0] in_value,
    input  logic [3:0]          allow_mask,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4:0]          imm_5bit,
    output logic [14:0]         imm_15bit,
    output logic [19:0]         imm_20bit,
    output logic [1:0]          mux4to1_select,
    output logic                out_hi,
    output logic                out_last,
    output logic [CntWidth-1:0] split_count
);

    typedef enum logic [1:0] {IDLE, EMIT_ONE, EMIT_HI, EMIT_LO} state_t;

    localparam logic [1:0] SEL_Z5  = 2'b00;
    localparam logic [1:0] SEL_S15 = 2'b01;
    localparam logic [1:0] SEL_Z15 = 2'b10;
    localparam logic [1:0] SEL_S20 = 2'b11;

    state_t      state;
    logic [11:0] lo_bits;
    logic [2:0]  pick;

    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] c);
        return (&c) ? c : c + CntWidth'(1);
    endfunction

    // Returns {match, select}; first enabled form in priority order wins.
    function automatic logic [2:0] pick_form(input logic [DataSize-1:0] v,
                                             input logic [3:0] m);
        logic fit_z5, fit_s15, fit_z15, fit_s20;
        fit_z5  = (v[31:5] == '0);
        fit_s15 = (v[31:14] == '0) || (&v[31:14]);
        fit_z15 = (v[31:15] == '0);
        fit_s20 = (v[31:19] == '0) || (&v[31:19]);
        if (m[0] && fit_z5)       return {1'b1, SEL_Z5};
        else if (m[1] && fit_s15) return {1'b1, SEL_S15};
        else if (m[2] && fit_z15) return {1'b1, SEL_Z15};
        else if (m[3] && fit_s20) return {1'b1, SEL_S20};
        else                      return {1'b0, SEL_Z5};
    endfunction

    assign pick = pick_form(in_value, allow_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            in_ready       <= 1'b1;
            out_valid      <= 1'b0;
            imm_5bit       <= '0;
            imm_15bit      <= '0;
            imm_20bit      <= '0;
            mux4to1_select <= SEL_Z5;
            out_hi         <= 1'b0;
            out_last       <= 1'b0;
            split_count    <= '0;
            lo_bits        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_valid <= 1'b1;
                        in_ready  <= 1'b0;
                        if (pick[2]) begin
                            state          <= EMIT_ONE;
                            mux4to1_select <= pick[1:0];
                            imm_5bit       <= (pick[1:0] == SEL_Z5) ? in_value[4:0] : '0;
                            imm_15bit      <= (pick[1:0] == SEL_S15 || pick[1:0] == SEL_Z15)
                                              ? in_value[14:0] : '0;
                            imm_20bit      <= (pick[1:0] == SEL_S20) ? in_value[19:0] : '0;
                            out_hi         <= 1'b0;
                            out_last       <= 1'b1;
                        end else begin
                            state          <= EMIT_HI;
                            mux4to1_select <= SEL_S20;
                            imm_5bit       <= '0;
                            imm_15bit      <= '0;
                            imm_20bit      <= in_value[31:12];
                            out_hi         <= 1'b1;
                            out_last       <= 1'b0;
                            lo_bits        <= in_value[11:0];
                            split_count    <= sat_inc(split_count);
                        end
                    end
                end
                EMIT_HI: begin
                    if (out_ready) begin
                        state          <= EMIT_LO;
                        mux4to1_select <= SEL_Z15;
                        imm_20bit      <= '0;
                        imm_15bit      <= {3'b000, lo_bits};
                        out_hi         <= 1'b0;
                        out_last       <= 1'b1;
                    end
                end
                EMIT_ONE, EMIT_LO: begin
                    if (out_ready) begin
                        state          <= IDLE;
                        in_ready       <= 1'b1;
                        out_valid      <= 1'b0;
                        imm_5bit       <= '0;
                        imm_15bit      <= '0;
                        imm_20bit      <= '0;
                        mux4to1_select <= SEL_Z5;
                        out_hi         <= 1'b0;
                        out_last       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_field_encoder.sv
// Bench for imm_field_encoder: directed vector table, random values against an
// arithmetic range model, backpressure, mid-split reset and counter saturation.
module tb_imm_field_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready, in_ready_s;
    logic [31:0] in_value;
    logic [3:0]  allow_mask;
    logic        out_valid, out_valid_s;
    logic        out_ready;
    logic [4:0]  imm_5bit, imm_5bit_s;
    logic [14:0] imm_15bit, imm_15bit_s;
    logic [19:0] imm_20bit, imm_20bit_s;
    logic [1:0]  sel, sel_s;
    logic        out_hi, out_hi_s, out_last, out_last_s;
    logic [15:0] split_count;
    logic [2:0]  sat_count;

    always #5 clk = ~clk;

    imm_field_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_value(in_value), .allow_mask(allow_mask), .out_valid(out_valid),
        .out_ready(out_ready), .imm_5bit(imm_5bit), .imm_15bit(imm_15bit),
        .imm_20bit(imm_20bit), .mux4to1_select(sel), .out_hi(out_hi),
        .out_last(out_last), .split_count(split_count)
    );

    // Narrow-counter twin driven in lockstep so saturation is reachable quickly.
    imm_field_encoder #(.CntWidth(3)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_value(in_value), .allow_mask(allow_mask), .out_valid(out_valid_s),
        .out_ready(out_ready), .imm_5bit(imm_5bit_s), .imm_15bit(imm_15bit_s),
        .imm_20bit(imm_20bit_s), .mux4to1_select(sel_s), .out_hi(out_hi_s),
        .out_last(out_last_s), .split_count(sat_count)
    );

    typedef struct packed {
        logic        split;
        logic [1:0]  sel;
        logic [4:0]  f5;
        logic [14:0] f15;
        logic [19:0] f20;
        logic [14:0] lo;
    } exp_t;

    typedef struct {
        logic [31:0] value;
        logic [3:0]  mask;
        exp_t        e;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;
    int splits = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic exp_t mk(input logic split, input logic [1:0] s,
                                input logic [19:0] field, input logic [14:0] lo);
        exp_t e;
        e.split = split;
        e.sel   = s;
        e.f5    = (!split && s == 2'd0) ? field[4:0] : 5'd0;
        e.f15   = (!split && (s == 2'd1 || s == 2'd2)) ? field[14:0] : 15'd0;
        e.f20   = (split || s == 2'd3) ? field : 20'd0;
        e.lo    = lo;
        return e;
    endfunction

    // Reference: range tests on the constant viewed as unsigned/signed integers.
    function automatic exp_t model(input logic [31:0] v, input logic [3:0] m);
        longint u = longint'(v);
        longint s = longint'($signed(v));
        if (m[0] && u < 32)                        return mk(1'b0, 2'd0, 20'(u % 32), 15'd0);
        else if (m[1] && s >= -16384 && s < 16384) return mk(1'b0, 2'd1, 20'(u % 32768), 15'd0);
        else if (m[2] && u < 32768)                return mk(1'b0, 2'd2, 20'(u), 15'd0);
        else if (m[3] && s >= -524288 && s < 524288) return mk(1'b0, 2'd3, 20'(u % 1048576), 15'd0);
        else                                       return mk(1'b1, 2'd3, 20'(u / 4096), 15'(u % 4096));
    endfunction

    task automatic chk_counts();
        chk("split_count", 32'(split_count), (splits > 65535) ? 65535 : splits);
        chk("sat_count", 32'(sat_count), (splits > 7) ? 7 : splits);
    endtask

    task automatic chk_beat(input string tag, input logic [1:0] s, input logic [4:0] f5,
                            input logic [14:0] f15, input logic [19:0] f20,
                            input logic hi, input logic last);
        chk({tag, ".out_valid"}, 32'(out_valid), 1);
        chk({tag, ".in_ready"}, 32'(in_ready), 0);
        chk({tag, ".select"}, 32'(sel), 32'(s));
        chk({tag, ".imm_5bit"}, 32'(imm_5bit), 32'(f5));
        chk({tag, ".imm_15bit"}, 32'(imm_15bit), 32'(f15));
        chk({tag, ".imm_20bit"}, 32'(imm_20bit), 32'(f20));
        chk({tag, ".out_hi"}, 32'(out_hi), 32'(hi));
        chk({tag, ".out_last"}, 32'(out_last), 32'(last));
    endtask

    // Starts and ends on a falling edge with the encoder idle.
    task automatic run_one(input string tag, input logic [31:0] v, input logic [3:0] m,
                           input exp_t e);
        chk({tag, ".idle_in_ready"}, 32'(in_ready), 1);
        in_valid = 1'b1; in_value = v; allow_mask = m; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; in_value = $urandom; allow_mask = 4'($urandom);
        if (e.split) splits++;
        chk_beat({tag, ".b1"}, e.sel, e.f5, e.f15, e.f20, e.split, !e.split);
        out_ready = 1'b1;
        @(negedge clk);
        if (e.split) begin
            chk_beat({tag, ".lo"}, 2'd2, 5'd0, e.lo, 20'd0, 1'b0, 1'b1);
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk({tag, ".done_valid"}, 32'(out_valid), 0);
        chk({tag, ".done_in_ready"}, 32'(in_ready), 1);
        chk_counts();
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_value = '0; allow_mask = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        splits = 0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[12];
        exp_t e;
        logic [31:0] v;
        logic [3:0]  m;

        tbl[0]  = '{32'h0000_001F, 4'hF, mk(1'b0, 2'd0, 20'h0001F, 15'h0)};
        tbl[1]  = '{32'hFFFF_C000, 4'hF, mk(1'b0, 2'd1, 20'h04000, 15'h0)};
        tbl[2]  = '{32'hFFFF_C000, 4'hD, mk(1'b0, 2'd3, 20'hFC000, 15'h0)};
        tbl[3]  = '{32'h0000_7FFF, 4'hF, mk(1'b0, 2'd2, 20'h07FFF, 15'h0)};
        tbl[4]  = '{32'h0000_7FFF, 4'hB, mk(1'b0, 2'd3, 20'h07FFF, 15'h0)};
        tbl[5]  = '{32'h1234_5678, 4'hF, mk(1'b1, 2'd3, 20'h12345, 15'h0678)};
        tbl[6]  = '{32'h0000_0020, 4'h1, mk(1'b1, 2'd3, 20'h00000, 15'h0020)};
        tbl[7]  = '{32'h0000_001F, 4'h0, mk(1'b1, 2'd3, 20'h00000, 15'h001F)};
        tbl[8]  = '{32'hFFFF_FFFF, 4'hF, mk(1'b0, 2'd1, 20'h07FFF, 15'h0)};
        tbl[9]  = '{32'h0007_FFFF, 4'hF, mk(1'b0, 2'd3, 20'h7FFFF, 15'h0)};
        tbl[10] = '{32'h0008_0000, 4'hF, mk(1'b1, 2'd3, 20'h00080, 15'h0000)};
        tbl[11] = '{32'hFFF8_0000, 4'hF, mk(1'b0, 2'd3, 20'h80000, 15'h0)};

        do_reset();
        chk("rst.in_ready", 32'(in_ready), 1);
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.fields", {imm_5bit, imm_15bit, 12'(imm_20bit)}, 0);
        chk("rst.imm_20bit", 32'(imm_20bit), 0);
        chk("rst.flags", {27'd0, sel, out_hi, out_last, 1'b0}, 0);
        chk_counts();

        // out_ready with nothing pending must not disturb the idle encoder
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        chk("idle_ready.out_valid", 32'(out_valid), 0);
        chk("idle_ready.in_ready", 32'(in_ready), 1);

        foreach (tbl[i]) run_one($sformatf("tbl%0d", i), tbl[i].value, tbl[i].mask, tbl[i].e);

        // Backpressure on a HI beat, with inputs scrambled meanwhile
        in_valid = 1'b1; in_value = 32'h8000_0000; allow_mask = 4'hF; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        splits++;
        for (int k = 0; k < 5; k++) begin
            in_value = $urandom; allow_mask = 4'($urandom);
            chk_beat($sformatf("bp%0d", k), 2'd3, 5'd0, 15'd0, 20'h80000, 1'b1, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk_beat("bp.lo", 2'd2, 5'd0, 15'h0000, 20'd0, 1'b0, 1'b1);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp.done_in_ready", 32'(in_ready), 1);
        chk_counts();

        // Reset while a split is pending on its HI beat
        in_valid = 1'b1; in_value = 32'h1234_5678; allow_mask = 4'hF;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid.out_hi", 32'(out_hi), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        splits = 0;
        chk("mid.out_valid", 32'(out_valid), 0);
        chk("mid.in_ready", 32'(in_ready), 1);
        chk("mid.imm_20bit", 32'(imm_20bit), 0);
        chk("mid.out_hi", 32'(out_hi), 0);
        chk_counts();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("mid.no_lo_beat", 32'(out_valid), 0);

        // Nine splits drive the 3-bit counter into saturation
        for (int k = 0; k < 9; k++)
            run_one($sformatf("sat%0d", k), 32'h4000_0000 + 32'(k), 4'hF,
                    model(32'h4000_0000 + 32'(k), 4'hF));
        chk("sat.held", 32'(sat_count), 7);

        for (int k = 0; k < 250; k++) begin
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = ~v;
            m = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            e = model(v, m);
            run_one($sformatf("rnd%0d_%08h_%1h", k, v, m), v, m, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
